// File: rtl/color_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : color_scan_pkg                                                  |
// | Purpose  : Shared types and helpers for the colour-sensor scan controller. |
// |            Holds the FSM state enum, the channel enum, the filter-select   |
// |            codes driven on {s2,s3}, and the channel sequencing helpers.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package color_scan_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    ARM     = 3'd2,
    MEASURE = 3'd3,
    STORE   = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Enum order is also the scan order.
  typedef enum logic [1:0] {
    RED   = 2'd0,
    BLUE  = 2'd1,
    GREEN = 2'd2,
    CLEAR = 2'd3
  } chan_e;

  // Photodiode filter codes as {s2,s3}.
  localparam logic [1:0] FILTER_RED   = 2'b00;
  localparam logic [1:0] FILTER_BLUE  = 2'b01;
  localparam logic [1:0] FILTER_GREEN = 2'b11;
  localparam logic [1:0] FILTER_CLEAR = 2'b10;

  function automatic logic [1:0] filter_code(input chan_e ch);
    logic [1:0] code;
    case (ch)
      RED:     code = FILTER_RED;
      BLUE:    code = FILTER_BLUE;
      GREEN:   code = FILTER_GREEN;
      default: code = FILTER_CLEAR;
    endcase
    return code;
  endfunction

  function automatic chan_e next_chan(input chan_e ch);
    chan_e nxt;
    case (ch)
      RED:     nxt = BLUE;
      BLUE:    nxt = GREEN;
      GREEN:   nxt = CLEAR;
      default: nxt = RED;
    endcase
    return nxt;
  endfunction

endpackage : color_scan_pkg
`default_nettype wire

// File: rtl/color_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : color_scan_if                                                   |
// | Purpose  : Bundles the scan handshake, the sensor pins and the four        |
// |            channel results of the colour scan controller.                  |
// | Ports    : start, sensor_out (to controller); s0..s3, busy, done, timeout, |
// |            red, blue, green, clear (from controller).                      |
// |            master = requester / sensor side, slave = controller.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface color_scan_if #(
  parameter int CNT_W = 21
);
  logic             start;
  logic             sensor_out;
  logic             s0;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] red;
  logic [CNT_W-1:0] blue;
  logic [CNT_W-1:0] green;
  logic [CNT_W-1:0] clear;

  modport master (
    output start, sensor_out,
    input  s0, s1, s2, s3, busy, done, timeout, red, blue, green, clear
  );

  modport slave (
    input  start, sensor_out,
    output s0, s1, s2, s3, busy, done, timeout, red, blue, green, clear
  );

endinterface : color_scan_if
`default_nettype wire

// File: rtl/color_scan_controller_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sensor_period_meter                                             |
// | Purpose  : Synchronises the sensor frequency output, detects its falling   |
// |            edges and measures the summed length of NUM_PERIODS periods,    |
// |            with a per-edge timeout.                                        |
// | Ports    : clk_50M, rst        - clock, async active-high reset            |
// |            sensor_out_i        - raw asynchronous sensor pin               |
// |            arm_i               - waiting for the first edge (timer only)   |
// |            measure_i           - accumulating between edges                |
// |            edge_o              - registered falling-edge strobe            |
// |            result_o            - averaged period, saturated to CNT_W bits  |
// |            result_valid_o      - result_o is final this cycle              |
// |            timed_out_o         - no edge within TIMEOUT_CYCLES             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sensor_period_meter #(
  parameter int NUM_PERIODS    = 4,      // power of two, 1..16
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_W          = 21
) (
  input  wire logic             clk_50M,
  input  wire logic             rst,
  input  wire logic             sensor_out_i,
  input  wire logic             arm_i,
  input  wire logic             measure_i,
  output logic                  edge_o,
  output logic [CNT_W-1:0]      result_o,
  output logic                  result_valid_o,
  output logic                  timed_out_o
);

  // Four spare bits keep NUM_PERIODS * TIMEOUT_CYCLES from wrapping.
  localparam int ACC_W = CNT_W + 4;
  localparam int SHIFT = $clog2(NUM_PERIODS);
  localparam int PER_W = $clog2(NUM_PERIODS + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             sync_q0;
  logic             sync_q1;
  logic             edge_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [PER_W-1:0] per_q;
  logic [PER_W-1:0] per_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic [ACC_W-1:0] acc_inc;
  logic [ACC_W-1:0] avg;
  logic             active;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      sync_q0 <= 1'b0;
      sync_q1 <= 1'b0;
      edge_q  <= 1'b0;
      acc_q   <= '0;
      per_q   <= '0;
      tmr_q   <= '0;
    end else begin
      sync_q0 <= sensor_out_i;
      sync_q1 <= sync_q0;
      // sync_q1 holds the older sample: 1 -> 0 is a falling edge.
      edge_q  <= sync_q1 & ~sync_q0;
      acc_q   <= acc_d;
      per_q   <= per_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    active  = arm_i | measure_i;
    acc_inc = acc_q + 1'b1;

    // The accumulator sits at zero outside MEASURE, so the first MEASURE
    // cycle starts counting from the edge that ended ARM.
    acc_d = measure_i ? acc_inc : '0;

    per_d = '0;
    if (measure_i) begin
      per_d = edge_q ? per_q + 1'b1 : per_q;
    end

    tmr_d = (!active || edge_q) ? '0 : tmr_q + 1'b1;

    // acc_q lags by one cycle; the closing edge cycle itself is counted via
    // acc_inc so the sum spans exactly NUM_PERIODS full periods.
    avg      = acc_inc >> SHIFT;
    result_o = (|avg[ACC_W-1:CNT_W]) ? '1 : avg[CNT_W-1:0];

    result_valid_o = measure_i & edge_q & (per_q == PER_W'(NUM_PERIODS - 1));
    // An edge arriving on the last allowed cycle still counts.
    timed_out_o    = active & ~edge_q & (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
    edge_o         = edge_q;
  end

endmodule : sensor_period_meter
`default_nettype wire

// File: rtl/color_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : color_scan_controller                                           |
// | Purpose  : On a start request, steps the TCS3200-style sensor through the  |
// |            red, blue, green and clear filters, lets each settle, measures  |
// |            the averaged output period and presents all four results with   |
// |            a single done pulse.                                            |
// | Ports    : clk_50M, rst  - 50 MHz clock, async active-high reset           |
// |            bus (slave)   - start / sensor_out in; s0..s3, busy, done,      |
// |                            timeout, red, blue, green, clear out            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module color_scan_controller
  import color_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2500,
  parameter int NUM_PERIODS    = 4,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_W          = 21
) (
  input  wire logic    clk_50M,
  input  wire logic    rst,
  color_scan_if.slave  bus
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  state_e                  state_q,   state_d;
  chan_e                   ch_q,      ch_d;
  logic [SET_W-1:0]        settle_q,  settle_d;
  logic [CNT_W-1:0]        cur_res_q, cur_res_d;
  logic                    flag_q,    flag_d;
  logic [3:0][CNT_W-1:0]   res_q,     res_d;
  logic [CNT_W-1:0]        red_q,     red_d;
  logic [CNT_W-1:0]        blue_q,    blue_d;
  logic [CNT_W-1:0]        green_q,   green_d;
  logic [CNT_W-1:0]        clear_q,   clear_d;
  logic                    timeout_q, timeout_d;

  logic                    arm_en;
  logic                    meas_en;
  logic                    m_edge;
  logic [CNT_W-1:0]        m_result;
  logic                    m_valid;
  logic                    m_timed_out;

  sensor_period_meter #(
    .NUM_PERIODS    (NUM_PERIODS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_meter (
    .clk_50M        (clk_50M),
    .rst            (rst),
    .sensor_out_i   (bus.sensor_out),
    .arm_i          (arm_en),
    .measure_i      (meas_en),
    .edge_o         (m_edge),
    .result_o       (m_result),
    .result_valid_o (m_valid),
    .timed_out_o    (m_timed_out)
  );

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= RED;
      settle_q  <= '0;
      cur_res_q <= '0;
      flag_q    <= 1'b0;
      res_q     <= '0;
      red_q     <= '0;
      blue_q    <= '0;
      green_q   <= '0;
      clear_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      settle_q  <= settle_d;
      cur_res_q <= cur_res_d;
      flag_q    <= flag_d;
      res_q     <= res_d;
      red_q     <= red_d;
      blue_q    <= blue_d;
      green_q   <= green_d;
      clear_q   <= clear_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    settle_d  = '0;
    cur_res_d = cur_res_q;
    flag_d    = flag_q;
    res_d     = res_q;
    red_d     = red_q;
    blue_d    = blue_q;
    green_d   = green_q;
    clear_d   = clear_q;
    timeout_d = timeout_q;
    arm_en    = 1'b0;
    meas_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SELECT;
          ch_d      = RED;
          flag_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end

      SELECT: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = ARM;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ARM: begin
        arm_en = 1'b1;
        if (m_timed_out) begin
          cur_res_d = '1;
          flag_d    = 1'b1;
          state_d   = STORE;
        end else if (m_edge) begin
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        meas_en = 1'b1;
        if (m_valid) begin
          cur_res_d = m_result;
          state_d   = STORE;
        end else if (m_timed_out) begin
          cur_res_d = '1;
          flag_d    = 1'b1;
          state_d   = STORE;
        end
      end

      STORE: begin
        res_d[ch_q] = cur_res_q;
        if (ch_q == CLEAR) begin
          // Publish everything at once so the outputs are valid in the
          // same cycle that done is high.
          red_d     = res_q[RED];
          blue_d    = res_q[BLUE];
          green_d   = res_q[GREEN];
          clear_d   = cur_res_q;
          timeout_d = flag_q;
          state_d   = DONE;
        end else begin
          ch_d    = next_chan(ch_q);
          state_d = SELECT;
        end
      end

      DONE: begin
        ch_d    = RED;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outside IDLE the sensor runs at 20 % scaling; IDLE powers it down.
  assign bus.s0 = (state_q != IDLE);
  assign bus.s1 = 1'b0;
  assign {bus.s2, bus.s3} = (state_q != IDLE) ? filter_code(ch_q) : 2'b00;

  assign bus.busy    = (state_q == SELECT) || (state_q == ARM) ||
                       (state_q == MEASURE) || (state_q == STORE);
  assign bus.done    = (state_q == DONE);
  assign bus.timeout = timeout_q;
  assign bus.red     = red_q;
  assign bus.blue    = blue_q;
  assign bus.green   = green_q;
  assign bus.clear   = clear_q;

endmodule : color_scan_controller
`default_nettype wire

// File: tb/tb_color_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_color_scan_controller                                        |
// | Purpose  : Directed self-checking bench for color_scan_controller with a   |
// |            square-wave sensor model whose period follows {s2,s3}.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_color_scan_controller;

  localparam int SETTLE = 10;
  localparam int NPER   = 4;
  // The per-filter periods go up to 1543 cycles, so the per-edge timeout
  // must sit above that for those channels to complete.
  localparam int TMO    = 2000;
  localparam int CW     = 21;
  localparam logic [CW-1:0] ALL_ONES = {CW{1'b1}};
  localparam int SCAN_BOUND = 30000;

  logic clk_50M;
  logic rst;

  color_scan_if #(.CNT_W(CW)) bus ();

  color_scan_controller #(
    .SETTLE_CYCLES  (SETTLE),
    .NUM_PERIODS    (NPER),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .bus     (bus)
  );

  initial begin
    clk_50M = 1'b0;
    forever #5 clk_50M = ~clk_50M;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sensor model: each iteration starts with a falling edge, so fall-to-fall
  // spacing is exactly the chosen period. per_a / per_b alternate.
  int per_a [4];
  int per_b [4];
  bit stuck_green = 1'b0;

  initial begin : sensor_model
    bit phase;
    int p;
    int idx;
    phase = 1'b0;
    bus.sensor_out = 1'b1;
    forever begin
      idx = int'({bus.s2, bus.s3});
      if (stuck_green && idx == 3) begin
        bus.sensor_out = 1'b1;
        @(negedge clk_50M);
      end else begin
        p = phase ? per_b[idx] : per_a[idx];
        if (p < 2) p = 100;
        phase = ~phase;
        bus.sensor_out = 1'b0;
        repeat (p / 2) @(negedge clk_50M);
        bus.sensor_out = 1'b1;
        repeat (p - p / 2) @(negedge clk_50M);
      end
    end
  end

  // Monitor: done pulses, result stability, scaling pins, filter sequence.
  int done_cnt = 0;
  int chg_bad  = 0;
  int scale_bad = 0;
  int nseq = 0;
  int run  = 0;
  int min_run = 0;
  logic [7:0]      seq_word;
  logic [1:0]      last_code;
  logic [4*CW-1:0] prev_res;

  always @(negedge clk_50M) begin
    if (bus.done) done_cnt++;
    if (!rst && !bus.done && ({bus.red, bus.blue, bus.green, bus.clear} !== prev_res))
      chg_bad++;
    prev_res = {bus.red, bus.blue, bus.green, bus.clear};
    if (!rst && bus.busy) begin
      if (!(bus.s0 === 1'b1 && bus.s1 === 1'b0)) scale_bad++;
      if (run == 0 || {bus.s2, bus.s3} != last_code) begin
        if (run != 0 && run < min_run) min_run = run;
        seq_word  = {seq_word[5:0], bus.s2, bus.s3};
        last_code = {bus.s2, bus.s3};
        nseq++;
        run = 1;
      end else begin
        run++;
      end
    end
  end

  task automatic set_periods(input int a0, a1, a2, a3, input int b0, b1, b2, b3);
    per_a[0] = a0; per_a[1] = a1; per_a[2] = a2; per_a[3] = a3;
    per_b[0] = b0; per_b[1] = b1; per_b[2] = b2; per_b[3] = b3;
  endtask

  task automatic pulse_start();
    @(negedge clk_50M);
    bus.start = 1'b1;
    @(negedge clk_50M);
    bus.start = 1'b0;
  endtask

  task automatic wait_code(input string tag, input logic [1:0] code);
    int i;
    i = 0;
    while (!(bus.busy && {bus.s2, bus.s3} == code) && i < SCAN_BOUND) begin
      @(negedge clk_50M);
      i++;
    end
    check({tag, " reach_code"}, 64'({bus.busy, bus.s2, bus.s3}), 64'({1'b1, code}));
  endtask

  task automatic run_scan(input string tag,
                          input logic [CW-1:0] er, eb, eg, ec,
                          input logic eto, input bit extra_start);
    int d0;
    int i;
    nseq = 0; run = 0; min_run = 1 << 30; seq_word = '0;
    chg_bad = 0; scale_bad = 0;
    d0 = done_cnt;
    pulse_start();
    check({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
    check({tag, " timeout_cleared"}, 64'(bus.timeout), 64'd0);
    if (extra_start) begin
      wait_code(tag, 2'b01);
      repeat (150) @(negedge clk_50M);
      pulse_start();
      check({tag, " restart_ignored"}, 64'({bus.busy, bus.s2, bus.s3}), 64'(3'b101));
    end
    i = 0;
    while (!bus.done && i < SCAN_BOUND) begin
      @(negedge clk_50M);
      i++;
    end
    check({tag, " done_seen"}, 64'(bus.done), 64'd1);
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, " red"},   64'(bus.red),   64'(er));
    check({tag, " blue"},  64'(bus.blue),  64'(eb));
    check({tag, " green"}, 64'(bus.green), 64'(eg));
    check({tag, " clear"}, 64'(bus.clear), 64'(ec));
    check({tag, " timeout"}, 64'(bus.timeout), 64'(eto));
    if (run < min_run) min_run = run;
    check({tag, " filter_count"}, 64'(nseq), 64'd4);
    check({tag, " filter_order"}, 64'(seq_word), 64'(8'b00_01_11_10));
    check({tag, " filter_hold_ok"}, 64'(min_run >= SETTLE), 64'd1);
    check({tag, " scaling_pins"}, 64'(scale_bad), 64'd0);
    check({tag, " results_held"}, 64'(chg_bad), 64'd0);
    repeat (5) @(negedge clk_50M);
    check({tag, " one_done"}, 64'(done_cnt - d0), 64'd1);
    check({tag, " timeout_hold"}, 64'(bus.timeout), 64'(eto));
    check({tag, " red_hold"}, 64'(bus.red), 64'(er));
    check({tag, " idle_s0"}, 64'({bus.s0, bus.s1, bus.s2, bus.s3}), 64'd0);
  endtask

  initial begin : watchdog
    #(950_000);
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : main
    int d0;
    bus.start = 1'b0;
    rst = 1'b1;
    set_periods(100, 100, 100, 100, 100, 100, 100, 100);
    repeat (3) @(negedge clk_50M);

    check("rst pins", 64'({bus.s0, bus.s1, bus.s2, bus.s3}), 64'd0);
    check("rst busy_done_to", 64'({bus.busy, bus.done, bus.timeout}), 64'd0);
    check("rst results", 64'({bus.red, bus.blue, bus.green, bus.clear}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk_50M);

    run_scan("basic", 100, 100, 100, 100, 1'b0, 1'b0);

    // Index is {s2,s3}: 00 red, 01 blue, 10 clear, 11 green.
    set_periods(1010, 1370, 480, 1543, 1010, 1370, 480, 1543);
    run_scan("perfilt", 1010, 1370, 1543, 480, 1'b0, 1'b0);

    set_periods(99, 99, 99, 99, 101, 101, 101, 101);
    run_scan("alt99", 100, 100, 100, 100, 1'b0, 1'b0);

    set_periods(100, 100, 100, 100, 101, 101, 101, 101);
    run_scan("trunc", 100, 100, 100, 100, 1'b0, 1'b0);

    set_periods(100, 100, 100, 100, 100, 100, 100, 100);
    stuck_green = 1'b1;
    run_scan("stuck", 100, 100, ALL_ONES, 100, 1'b1, 1'b0);
    stuck_green = 1'b0;
    run_scan("recover", 100, 100, 100, 100, 1'b0, 1'b0);

    set_periods(120, 120, 120, 120, 120, 120, 120, 120);
    run_scan("dblstart", 120, 120, 120, 120, 1'b0, 1'b1);

    // Reset during the green settle window.
    d0 = done_cnt;
    pulse_start();
    wait_code("rstmid", 2'b11);
    repeat (3) @(negedge clk_50M);
    #2;
    rst = 1'b1;
    bus.start = 1'b1;
    #1;
    check("rstmid pins", 64'({bus.s0, bus.s1, bus.s2, bus.s3}), 64'd0);
    check("rstmid busy", 64'(bus.busy), 64'd0);
    check("rstmid results", 64'({bus.red, bus.blue, bus.green, bus.clear}), 64'd0);
    repeat (3) @(negedge clk_50M);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk_50M);
    check("rstmid start_lost", 64'(bus.busy), 64'd0);
    check("rstmid no_done", 64'(done_cnt - d0), 64'd0);

    set_periods(100, 100, 100, 100, 100, 100, 100, 100);
    run_scan("after_rst", 100, 100, 100, 100, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_color_scan_controller
`default_nettype wire
